// File: rtl/regfile_scoreboard_pkg.sv
// Shared types and constants for the register-file read-side scoreboard.
package regfile_scoreboard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam int unsigned AGE_W       = 2;
  localparam int unsigned ISSUE_AGE_C = 3;

  // Operand source for a producer that is still in flight (forwarding build).
  function automatic fwd_sel_t fwd_classify(input logic [AGE_W-1:0] age, input logic ld);
    if (age == AGE_W'(3) && !ld) return FWD_MEM;
    else if (age == AGE_W'(2))   return FWD_WB;
    else                         return FWD_RF;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_age.sv
// Per-register in-flight age and load flag; a new issue takes priority over decrement.
module sb_age_cell
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned ISSUE_AGE = ISSUE_AGE_C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic             set_ld,
  output logic [AGE_W-1:0] age,
  output logic             ld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age <= '0;
      ld  <= 1'b0;
    end else if (set) begin
      age <= AGE_W'(ISSUE_AGE);
      ld  <= set_ld;
    end else if (age != '0) begin
      age <= age - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// ID-stage hazard controller: combinational stall plus registered EX forwarding selects.
// Define REGFILE_FWD_EN for forwarding; otherwise the block interlocks until writeback.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned ISSUE_AGE = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [ADDR_W-1:0]    id_rs1,
  input  logic [ADDR_W-1:0]    id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [ADDR_W-1:0]    id_rd,
  input  logic                 id_reg_write,
  input  logic                 id_is_load,
  input  logic                 ex_flush,
  output logic                 stall,
  output logic [1:0]           fwd_a_ex,
  output logic [1:0]           fwd_b_ex,
  output logic [REG_COUNT-1:0] pending_mask
);

  logic [AGE_W-1:0]     age [REG_COUNT];
  logic [REG_COUNT-1:0] ld;
  logic                 issue;
  logic                 haz_a, haz_b, stall_a, stall_b;
  logic [AGE_W-1:0]     age_a, age_b;
  logic                 ld_a, ld_b;
  fwd_sel_t             sel_a, sel_b, fwd_a_q, fwd_b_q;

  assign age[0] = '0;
  assign ld[0]  = 1'b0;

  assign issue = id_valid & id_reg_write & (id_rd != '0) & ~stall & ~ex_flush;

  for (genvar r = 1; r < REG_COUNT; r++) begin : g_cell
    sb_age_cell #(.ISSUE_AGE(ISSUE_AGE)) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .set    (issue && (id_rd == ADDR_W'(r))),
      .set_ld (id_is_load),
      .age    (age[r]),
      .ld     (ld[r])
    );
  end

  always_comb begin
    for (int unsigned r = 0; r < REG_COUNT; r++) begin
      pending_mask[r] = (age[r] > AGE_W'(1));
    end
  end

  always_comb begin
    haz_a = id_valid & id_use_rs1 & (id_rs1 != '0);
    haz_b = id_valid & id_use_rs2 & (id_rs2 != '0);
    age_a = age[id_rs1];
    age_b = age[id_rs2];
    ld_a  = ld[id_rs1];
    ld_b  = ld[id_rs2];
`ifdef REGFILE_FWD_EN
    stall_a = haz_a & (age_a == AGE_W'(3)) & ld_a;
    stall_b = haz_b & (age_b == AGE_W'(3)) & ld_b;
    sel_a   = haz_a ? fwd_classify(age_a, ld_a) : FWD_RF;
    sel_b   = haz_b ? fwd_classify(age_b, ld_b) : FWD_RF;
`else
    // Load producers wait exactly like ALU producers; the load term is subsumed by age >= 2.
    stall_a = haz_a & (((age_a == AGE_W'(3)) & ld_a) | (age_a >= AGE_W'(2)));
    stall_b = haz_b & (((age_b == AGE_W'(3)) & ld_b) | (age_b >= AGE_W'(2)));
    sel_a   = FWD_RF;
    sel_b   = FWD_RF;
`endif
    stall = stall_a | stall_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (stall || ex_flush || !id_valid) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= sel_a;
      fwd_b_q <= sel_b;
    end
  end

  assign fwd_a_ex = fwd_a_q;
  assign fwd_b_ex = fwd_b_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard; the model tracks each register's issue cycle.
module tb_regfile_scoreboard;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_load, ex_flush;
  logic [4:0]   id_rs1, id_rs2, id_rd;
  logic         stall;
  logic [1:0]   fwd_a_ex, fwd_b_ex;
  logic [N-1:0] pending_mask;

  regfile_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .ex_flush     (ex_flush),
    .stall        (stall),
    .fwd_a_ex     (fwd_a_ex),
    .fwd_b_ex     (fwd_b_ex),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         icyc [N];
  bit         issued [N];
  bit         ild [N];
  logic [1:0] m_fwd_a = 2'b00;
  logic [1:0] m_fwd_b = 2'b00;

`ifdef REGFILE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Cycles left until the writeback, derived from when the newest producer issued.
  function automatic int m_age(input int r);
    int d;
    if (r == 0 || !issued[r]) return 0;
    d = cyc - icyc[r];
    return (3 - d > 0) ? 3 - d : 0;
  endfunction

  function automatic bit m_haz(input logic u, input logic [4:0] s);
    return id_valid && u && (s != 5'd0);
  endfunction

  function automatic bit m_stall_src(input logic u, input logic [4:0] s);
    int a;
    if (!m_haz(u, s)) return 1'b0;
    a = m_age(int'(s));
    if (FWD) return (a == 3) && ild[s];
    return a >= 2;
  endfunction

  function automatic bit m_stall();
    return m_stall_src(id_use_rs1, id_rs1) || m_stall_src(id_use_rs2, id_rs2);
  endfunction

  function automatic logic [1:0] m_sel(input logic u, input logic [4:0] s);
    int a;
    if (!FWD || !m_haz(u, s)) return 2'b00;
    a = m_age(int'(s));
    if (a == 3 && !ild[s]) return 2'b10;
    if (a == 2) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [N-1:0] m_mask();
    logic [N-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++) m[r] = (m_age(r) >= 2);
    return m;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < N; r++) begin
      issued[r] = 1'b0;
      ild[r]    = 1'b0;
    end
    m_fwd_a = 2'b00;
    m_fwd_b = 2'b00;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic fl);
    id_valid = v;  id_rs1 = rs1;  id_rs2 = rs2;  id_use_rs1 = u1;  id_use_rs2 = u2;
    id_rd = rd;  id_reg_write = rw;  id_is_load = ld;  ex_flush = fl;
    #1;
  endtask

  task automatic tick();
    bit         iss, bub;
    logic [1:0] na, nb;
    bub = m_stall() || ex_flush || !id_valid;
    iss = id_valid && id_reg_write && (id_rd != 5'd0) && !m_stall() && !ex_flush;
    na  = bub ? 2'b00 : m_sel(id_use_rs1, id_rs1);
    nb  = bub ? 2'b00 : m_sel(id_use_rs2, id_rs2);
    @(posedge clk);
    cyc++;
    if (iss) begin
      issued[id_rd] = 1'b1;
      icyc[id_rd]   = cyc;
      ild[id_rd]    = id_is_load;
    end
    m_fwd_a = na;
    m_fwd_b = nb;
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
    #3;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_checks++; if (pending_mask !== '0) begin n_fail++; $display("FAIL reset_mask: got %h want 0", pending_mask); end
    n_checks++; if (fwd_a_ex !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_a: got %b want 00", fwd_a_ex); end
    n_checks++; if (fwd_b_ex !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_b: got %b want 00", fwd_b_ex); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_back_to_back();
    int nst = 0;
    drive(1, 0, 0, 0, 0, 5'd5, 1, 0, 0);
    tick();
    drive(1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (stall !== m_stall()) begin n_fail++; $display("FAIL b2b_stall: got %b want %b", stall, m_stall()); end
      if (!stall) break;
      nst++;
      tick();
    end
    n_checks++;
    if (nst != (FWD ? 0 : 2)) begin n_fail++; $display("FAIL b2b_stall_cycles: got %0d want %0d", nst, FWD ? 0 : 2); end
    tick();
    n_checks++;
    if (fwd_a_ex !== (FWD ? 2'b10 : 2'b00) || fwd_a_ex !== m_fwd_a) begin
      n_fail++; $display("FAIL b2b_fwd_a: got %b want %b", fwd_a_ex, m_fwd_a);
    end
    idle(4);
  endtask

  task automatic test_load_use();
    int nst = 0;
    drive(1, 0, 0, 0, 0, 5'd7, 1, 1, 0);
    tick();
    drive(1, 5'd0, 5'd7, 0, 1, 5'd8, 1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (stall !== m_stall()) begin n_fail++; $display("FAIL lu_stall: got %b want %b", stall, m_stall()); end
      if (!stall) break;
      nst++;
      tick();
    end
    n_checks++;
    if (nst != (FWD ? 1 : 2)) begin n_fail++; $display("FAIL lu_stall_cycles: got %0d want %0d", nst, FWD ? 1 : 2); end
    tick();
    n_checks++;
    if (fwd_b_ex !== (FWD ? 2'b01 : 2'b00) || fwd_b_ex !== m_fwd_b) begin
      n_fail++; $display("FAIL lu_fwd_b: got %b want %b", fwd_b_ex, m_fwd_b);
    end
    idle(4);
  endtask

  task automatic test_x0();
    drive(1, 0, 0, 0, 0, 5'd0, 1, 1, 0);
    tick();
    n_checks++; if (pending_mask[0] !== 1'b0) begin n_fail++; $display("FAIL x0_mask0: got %b want 0", pending_mask[0]); end
    drive(1, 5'd0, 5'd0, 1, 1, 5'd4, 0, 0, 0);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall: got %b want 0", stall); end
    tick();
    n_checks++;
    if (fwd_a_ex !== 2'b00 || fwd_b_ex !== 2'b00) begin
      n_fail++; $display("FAIL x0_fwd: got %b/%b want 00/00", fwd_a_ex, fwd_b_ex);
    end
    n_checks++; if (pending_mask !== m_mask()) begin n_fail++; $display("FAIL x0_mask: got %h want %h", pending_mask, m_mask()); end
    idle(4);
  endtask

  task automatic test_rewrite();
    int nst = 0;
    drive(1, 0, 0, 0, 0, 5'd3, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 5'd3, 1, 0, 0);
    tick();
    drive(1, 5'd3, 5'd3, 1, 1, 5'd11, 1, 0, 0);
    n_checks++; if (pending_mask[3] !== 1'b1) begin n_fail++; $display("FAIL rw_pending: got %b want 1", pending_mask[3]); end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (stall !== m_stall()) begin n_fail++; $display("FAIL rw_stall: got %b want %b", stall, m_stall()); end
      if (!stall) break;
      nst++;
      tick();
    end
    n_checks++;
    if (nst != (FWD ? 0 : 2)) begin n_fail++; $display("FAIL rw_stall_cycles: got %0d want %0d", nst, FWD ? 0 : 2); end
    tick();
    n_checks++;
    if (fwd_a_ex !== (FWD ? 2'b10 : 2'b00) || fwd_b_ex !== fwd_a_ex) begin
      n_fail++; $display("FAIL rw_fwd: got %b/%b want %b/%b", fwd_a_ex, fwd_b_ex, m_fwd_a, m_fwd_b);
    end
    idle(4);
  endtask

  task automatic test_flush();
    drive(1, 0, 0, 0, 0, 5'd9, 1, 1, 0);
    tick();
    drive(1, 5'd9, 5'd0, 1, 0, 5'd10, 1, 0, 1);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fl_stall: got %b want 1", stall); end
    tick();
    n_checks++;
    if (fwd_a_ex !== 2'b00 || fwd_b_ex !== 2'b00) begin
      n_fail++; $display("FAIL fl_fwd: got %b/%b want 00/00", fwd_a_ex, fwd_b_ex);
    end
    n_checks++;
    if (pending_mask !== m_mask() || pending_mask[10] !== 1'b0 || pending_mask[9] !== 1'b1) begin
      n_fail++; $display("FAIL fl_mask: got %h want %h", pending_mask, m_mask());
    end
    idle(4);
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 0, 5'd5, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 5'd7, 1, 1, 0);
    tick();
    drive(1, 5'd7, 5'd0, 1, 0, 5'd1, 1, 0, 0);
    n_checks++; if (pending_mask !== 32'h0000_00A0) begin n_fail++; $display("FAIL rm_mask_before: got %h want 000000a0", pending_mask); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rm_stall_before: got %b want 1", stall); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (pending_mask !== '0) begin n_fail++; $display("FAIL rm_mask: got %h want 0", pending_mask); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rm_stall: got %b want 0", stall); end
    n_checks++;
    if (fwd_a_ex !== 2'b00 || fwd_b_ex !== 2'b00) begin
      n_fail++; $display("FAIL rm_fwd: got %b/%b want 00/00", fwd_a_ex, fwd_b_ex);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0);
      n_checks++;
      if (stall !== m_stall()) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, stall, m_stall()); end
      n_checks++;
      if (fwd_a_ex !== m_fwd_a || fwd_b_ex !== m_fwd_b) begin
        n_fail++; $display("FAIL rnd_fwd[%0d]: got %b/%b want %b/%b", i, fwd_a_ex, fwd_b_ex, m_fwd_a, m_fwd_b);
      end
      n_checks++;
      if (pending_mask !== m_mask()) begin n_fail++; $display("FAIL rnd_mask[%0d]: got %h want %h", i, pending_mask, m_mask()); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_x0();
    test_rewrite();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Read-side hazard controller for the 32x32 register file. The register file writes on the falling clock edge and reads combinationally.
- Sits in the decode (ID) stage. Tracks in-flight destination registers from issue until register-file writeback.
- Produces a combinational ID-stage stall, plus registered EX-stage forwarding selects for operands A and B.
- The register file is the writer end; this block governs when and where the reader end takes its operands.

Parameters:
- REG_COUNT, 32, number of architectural registers; register 0 is hardwired zero.
- ADDR_W, 5, register address width; must equal clog2(REG_COUNT).
- ISSUE_AGE, 3, age loaded on issue. Equals the cycles from leaving ID until the WB-stage falling-edge write.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  ADDR_W  source 1 address
- id_rs2  in  ADDR_W  source 2 address
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_rd  in  ADDR_W  destination address
- id_reg_write  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- ex_flush  in  1  squash the ID instruction (taken branch resolved in EX)
- stall  out  1  hold IF/ID; insert a bubble into EX (combinational)
- fwd_a_ex  out  2  EX operand A select (registered)
- fwd_b_ex  out  2  EX operand B select (registered)
- pending_mask  out  REG_COUNT  bit r set when age[r] > 1

Behaviour:
- State
  - Per register r: age[r] (2 bits) and ld[r] (producer is a load).
  - Register 0 is never tracked; its age is constant 0.
- Ready rule
  - Age ≤ 1 means the value comes from the register file, because the falling-edge write precedes the same-cycle read.
- Each rising edge
  - Every nonzero age decrements by 1.
  - If issue is true, age[id_rd] becomes ISSUE_AGE and ld[id_rd] becomes id_is_load.
  - Load wins over decrement on the same register.
  - Reissue to a pending rd restarts its age (newest producer wins).
- Issue = id_valid & id_reg_write & (id_rd != 0) & !stall & !ex_flush.
- A source s is a hazard source when id_valid & use_s & (s != 0).
- Forward select encoding: 00 = register file, 01 = from WB, 10 = from MEM.
- fwd_a_ex / fwd_b_ex
  - Registered from the per-source classification below.
  - Forced to 00 when stall, ex_flush or !id_valid (bubble).
- ex_flush with stall: flush wins. No issue, EX receives a bubble, stall output still reflects the hazard.
- Both sources depending on the same pending rd are classified identically.
- Reset (async, any time)
  - All age = 0, all ld = 0.
  - fwd_a_ex = fwd_b_ex = 00.
  - stall = 0 and pending_mask = 0 immediately after reset assertion.
  - Normal operation starts at the first rising edge after rst_n deasserts.
- Output latency: stall is 0-cycle (combinational); forwarding selects are 1-cycle.

Optional Feature:
- Macro: REGFILE_FWD_EN.
- Defined (forwarding)
  - stall = any hazard source with age 3 and ld set (load-use, exactly one bubble).
  - Age 3, non-load: select 10.
  - Age 2: select 01.
  - Age ≤ 1: select 00.
- Undefined (interlock only)
  - stall = any hazard source with age ≥ 2.
  - Selects are always 00.
  - ld[] is still tracked so pending_mask is unchanged.

Decomposition:
- Package regfile_scoreboard_pkg holds:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - AGE_W = 2 and ISSUE_AGE_C = 3 constants.
- One sub-module, sb_age_cell: a per-register age/ld counter with set-over-decrement priority and async clear. Instantiated REG_COUNT-1 times from a generate loop.

Test Plan:
- Back-to-back ALU dependency: issue add x5, next cycle a consumer with rs1 = x5.
  - With REGFILE_FWD_EN: stall = 0; fwd_a_ex = 10 the following cycle.
  - Without: stall = 1 for 2 cycles, then issue with fwd_a_ex = 00.
- Load-use: lw x7, then a consumer with rs2 = x7.
  - With REGFILE_FWD_EN: stall = 1 for exactly 1 cycle, then fwd_b_ex = 01.
  - Without: 2 stall cycles.
- Register 0: producer with rd = 0 followed by a consumer of x0 → no stall, selects 00, pending_mask bit 0 stays 0.
- Rewrite: issue to x3 twice, 1 cycle apart, then a consumer of x3 → age restarted at 3; forwarding follows the second producer (select 10).
- Flush during a load-use stall: ex_flush = 1 with stall = 1 → no issue, fwd outputs 00, pending_mask unchanged except for normal decrement.
- Reset mid-stream: assert rst_n = 0 while pending_mask = 0x00000A0 → pending_mask = 0 and stall = 0 without a clock edge; fwd outputs 00.
